// File: rtl/rename_pkg.sv
// Shared widths and slot types for the two-wide rename stage.
package rename_pkg;
   localparam int ARCH_REG_BITS = $clog2(32);
   localparam int PHYS_REG_BITS = $clog2(64);
   localparam int FREE_DEPTH    = 64 - 32;

   typedef logic [ARCH_REG_BITS-1:0] arch_reg_t;
   typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;

   typedef struct packed {
      logic      valid;
      phys_reg_t ps1;
      phys_reg_t ps2;
      phys_reg_t pd;
      phys_reg_t old_pd;
   } rename_slot_t;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers: up to two pops and two pushes per cycle.
module free_list
   import rename_pkg::*;
#(
   parameter int DEPTH = FREE_DEPTH,
   parameter int PW    = PHYS_REG_BITS,
   parameter int BASE  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         i_pop_cnt,
   output logic [PW-1:0]      o_head0,
   output logic [PW-1:0]      o_head1,
   input  logic [1:0]         i_push_valid,
   input  logic [1:0][PW-1:0] i_push_preg,
   output logic [PW:0]        o_count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_mem [DEPTH];
   logic [IW-1:0] r_head;
   logic [IW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [IW-1:0] w_head1;
   logic [IW-1:0] w_tail1;
   logic [CW-1:0] w_avail;
   logic [CW-1:0] w_cnt_mid;
   logic          w_push0;
   logic          w_push1;
   logic          w_nz0;
   logic          w_nz1;

   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
      return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   assign w_head1 = idx_inc(r_head);
   assign o_head0 = r_mem[r_head];
   assign o_head1 = r_mem[w_head1];
   assign o_count = r_count;

   // Pushes of preg 0, or ones that would overfill the list, are dropped.
   always_comb begin
      w_nz0     = i_push_valid[0] && (i_push_preg[0] != '0);
      w_nz1     = i_push_valid[1] && (i_push_preg[1] != '0);
      w_avail   = r_count - CW'(i_pop_cnt);
      w_push0   = w_nz0 && (w_avail < CW'(DEPTH));
      w_cnt_mid = w_avail + CW'(w_push0);
      w_push1   = w_nz1 && (w_cnt_mid < CW'(DEPTH));
      w_tail1   = w_push0 ? idx_inc(r_tail) : r_tail;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= CW'(DEPTH);
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= PW'(BASE + i);
      end else begin
         if (w_push0) r_mem[r_tail]  <= i_push_preg[0];
         if (w_push1) r_mem[w_tail1] <= i_push_preg[1];
         case (i_pop_cnt)
            2'd1:    r_head <= w_head1;
            2'd2:    r_head <= idx_inc(w_head1);
            default: r_head <= r_head;
         endcase
         r_tail  <= w_push1 ? idx_inc(w_tail1) : w_tail1;
         r_count <= w_cnt_mid + CW'(w_push1);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (w_avail + CW'(w_nz0) + CW'(w_nz1)) <= CW'(DEPTH));
endmodule

// File: rtl/register_rename.sv
// Two-wide register rename: RAT lookup with intra-group bypass, free-list allocation, one output register stage.
module register_rename
   import rename_pkg::*;
#(
   parameter int INPUT_ROWS   = 2,
   parameter int ARCH_REG_NUM = 32,
   parameter int PHYS_REG_NUM = 64
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [INPUT_ROWS-1:0]                           in_valid,
   input  logic [INPUT_ROWS-1:0][$clog2(ARCH_REG_NUM)-1:0] in_src_reg1,
   input  logic [INPUT_ROWS-1:0][$clog2(ARCH_REG_NUM)-1:0] in_src_reg2,
   input  logic [INPUT_ROWS-1:0][$clog2(ARCH_REG_NUM)-1:0] in_dest_reg,
   output logic                                            in_ready,
   output logic [INPUT_ROWS-1:0]                           out_valid,
   output logic [INPUT_ROWS-1:0][$clog2(PHYS_REG_NUM)-1:0] out_ps1,
   output logic [INPUT_ROWS-1:0][$clog2(PHYS_REG_NUM)-1:0] out_ps2,
   output logic [INPUT_ROWS-1:0][$clog2(PHYS_REG_NUM)-1:0] out_pd,
   output logic [INPUT_ROWS-1:0][$clog2(PHYS_REG_NUM)-1:0] out_old_pd,
   input  logic                                            out_ready,
   input  logic [INPUT_ROWS-1:0]                           free_valid,
   input  logic [INPUT_ROWS-1:0][$clog2(PHYS_REG_NUM)-1:0] free_preg,
   output logic [$clog2(PHYS_REG_NUM):0]                   free_count
);
   localparam int PB = $clog2(PHYS_REG_NUM);

   phys_reg_t    r_rat [ARCH_REG_NUM];
   rename_slot_t r_out [2];

   rename_slot_t w_slot [2];
   phys_reg_t    w_head0;
   phys_reg_t    w_head1;
   logic [1:0]   w_pop_cnt;
   logic         w_advance;
   logic         w_accept;
   logic         w_alloc0;
   logic         w_alloc1;

   function automatic phys_reg_t rat_read(input arch_reg_t a);
      return (a == '0) ? '0 : r_rat[a];
   endfunction

   free_list #(
      .DEPTH (PHYS_REG_NUM - ARCH_REG_NUM),
      .PW    (PB),
      .BASE  (ARCH_REG_NUM)
   ) u_free_list (
      .clk          (clk),
      .rst          (rst),
      .i_pop_cnt    (w_pop_cnt),
      .o_head0      (w_head0),
      .o_head1      (w_head1),
      .i_push_valid (free_valid),
      .i_push_preg  (free_preg),
      .o_count      (free_count)
   );

   always_comb begin
      w_advance = !(r_out[0].valid || r_out[1].valid) || out_ready;
      in_ready  = w_advance && (free_count >= (PB + 1)'(2));
      w_accept  = in_ready && (|in_valid);
      w_alloc0  = in_valid[0] && (in_dest_reg[0] != '0);
      w_alloc1  = in_valid[1] && (in_dest_reg[1] != '0);
      w_pop_cnt = w_accept ? ({1'b0, w_alloc0} + {1'b0, w_alloc1}) : 2'd0;

      w_slot[0] = '0;
      w_slot[1] = '0;
      if (in_valid[0]) begin
         w_slot[0].valid = 1'b1;
         w_slot[0].ps1   = rat_read(in_src_reg1[0]);
         w_slot[0].ps2   = rat_read(in_src_reg2[0]);
         if (w_alloc0) begin
            w_slot[0].pd     = w_head0;
            w_slot[0].old_pd = rat_read(in_dest_reg[0]);
         end
      end
      // Slot1 sees slot0's fresh mapping when it names slot0's destination.
      if (in_valid[1]) begin
         w_slot[1].valid = 1'b1;
         w_slot[1].ps1   = (w_alloc0 && in_src_reg1[1] == in_dest_reg[0]) ? w_head0 : rat_read(in_src_reg1[1]);
         w_slot[1].ps2   = (w_alloc0 && in_src_reg2[1] == in_dest_reg[0]) ? w_head0 : rat_read(in_src_reg2[1]);
         if (w_alloc1) begin
            w_slot[1].pd     = w_alloc0 ? w_head1 : w_head0;
            w_slot[1].old_pd = (w_alloc0 && in_dest_reg[1] == in_dest_reg[0]) ? w_head0 : rat_read(in_dest_reg[1]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REG_NUM; i++) r_rat[i] <= phys_reg_t'(i);
         r_out[0] <= '0;
         r_out[1] <= '0;
      end else begin
         if (w_accept) begin
            if (w_alloc0) r_rat[in_dest_reg[0]] <= w_slot[0].pd;
            if (w_alloc1) r_rat[in_dest_reg[1]] <= w_slot[1].pd;
         end
         if (w_advance) begin
            if (w_accept) begin
               r_out[0] <= w_slot[0];
               r_out[1] <= w_slot[1];
            end else begin
               r_out[0].valid <= 1'b0;
               r_out[1].valid <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         out_valid[i]  = r_out[i].valid;
         out_ps1[i]    = r_out[i].ps1;
         out_ps2[i]    = r_out[i].ps2;
         out_pd[i]     = r_out[i].pd;
         out_old_pd[i] = r_out[i].old_pd;
      end
   end
endmodule
